// File: rtl/duty_ramp_ctrl.sv
// Duty-cycle ramp generator feeding the 100-step PWM stage.
// Moves duty by +/-1 every steps*TICK_DIV clocks until it reaches the latched target.
module duty_ramp_ctrl #(
  parameter int unsigned TICK_DIV = 125_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] target,
  input  logic [7:0] step_ticks,
  output logic [6:0] duty,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [6:0]    DUTY_MAX  = 7'd100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [6:0]    r_duty;
  logic          r_busy;
  logic          r_done;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_stepcnt;
  logic [6:0]    r_tgt;
  logic [7:0]    r_steps;
  logic          r_up;

  logic [1:0]    w_state_nxt;
  logic [6:0]    w_duty_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [7:0]    w_stepcnt_nxt;
  logic [6:0]    w_tgt_nxt;
  logic [7:0]    w_steps_nxt;
  logic          w_up_nxt;

  logic [6:0]    w_tgt_in;
  logic [7:0]    w_steps_in;
  logic          w_tick;
  logic          w_step;
  logic [6:0]    w_duty_step;

  assign w_tgt_in   = (target > DUTY_MAX) ? DUTY_MAX : target;
  assign w_steps_in = (step_ticks == 8'd0) ? 8'd1 : step_ticks;
  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_step     = w_tick && (r_stepcnt == (r_steps - 8'd1));

  // Saturating step keeps duty inside 0..100 even if the target were ever out of reach.
  always_comb begin
    w_duty_step = r_duty;
    if (r_up) begin
      if (r_duty < DUTY_MAX) w_duty_step = r_duty + 7'd1;
    end else begin
      if (r_duty != 7'd0) w_duty_step = r_duty - 7'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_duty_nxt    = r_duty;
    w_presc_nxt   = r_presc;
    w_stepcnt_nxt = r_stepcnt;
    w_tgt_nxt     = r_tgt;
    w_steps_nxt   = r_steps;
    w_up_nxt      = r_up;

    if (abort) begin
      w_state_nxt = S_IDLE;
    end else if (start) begin
      // A start is handled identically in every state: relatch, clear timing, re-decide.
      w_tgt_nxt     = w_tgt_in;
      w_steps_nxt   = w_steps_in;
      w_presc_nxt   = '0;
      w_stepcnt_nxt = '0;
      w_up_nxt      = (w_tgt_in > r_duty);
      w_state_nxt   = (w_tgt_in == r_duty) ? S_DONE : S_RAMP;
    end else begin
      case (r_state)
        S_RAMP: begin
          if (w_tick) begin
            w_presc_nxt = '0;
            if (w_step) begin
              w_stepcnt_nxt = '0;
              w_duty_nxt    = w_duty_step;
              if (w_duty_step == r_tgt) w_state_nxt = S_DONE;
            end else begin
              w_stepcnt_nxt = r_stepcnt + 8'd1;
            end
          end else begin
            w_presc_nxt = r_presc + PRESC_ONE;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_duty    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_presc   <= '0;
      r_stepcnt <= '0;
      r_tgt     <= '0;
      r_steps   <= '0;
      r_up      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_duty    <= w_duty_nxt;
      r_busy    <= (w_state_nxt == S_RAMP);
      r_done    <= (w_state_nxt == S_DONE);
      r_presc   <= w_presc_nxt;
      r_stepcnt <= w_stepcnt_nxt;
      r_tgt     <= w_tgt_nxt;
      r_steps   <= w_steps_nxt;
      r_up      <= w_up_nxt;
    end
  end

  assign duty = r_duty;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl with TICK_DIV = 4.
module tb_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [6:0] target;
  logic [7:0] step_ticks;
  logic [6:0] duty;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  duty_ramp_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .target     (target),
    .step_ticks (step_ticks),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    cyc(2);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; abort = 1'b0; target = 7'd0; step_ticks = 8'd0;
    cyc(3);
    rstn = 1'b1;
    n_tests++;
    if (duty !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: duty=%0d busy=%b done=%b, expected 0 0 0", duty, busy, done);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      n_tests++;
      if (duty !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: duty=%0d busy=%b done=%b, expected 0 0 0", i, duty, busy, done);
      end
    end
  endtask

  task automatic test_up_ramp();
    logic [6:0] exp_duty;
    start = 1'b1; target = 7'd5; step_ticks = 8'd2;
    cyc(1);
    start = 1'b0;
    n_tests++;
    if (duty !== 7'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL up_start: duty=%0d busy=%b done=%b, expected 0 1 0", duty, busy, done);
    end
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      exp_duty = 7'(k / 8);
      n_tests++;
      if (duty !== exp_duty || busy !== (k < 40) || done !== (k == 40)) begin
        n_fail++;
        $display("FAIL up_ramp[+%0d]: duty=%0d busy=%b done=%b, expected %0d %b %b",
                 k, duty, busy, done, exp_duty, (k < 40), (k == 40));
      end
    end
    cyc(1);
    n_tests++;
    if (duty !== 7'd5 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL up_after_done: duty=%0d busy=%b done=%b, expected 5 0 0", duty, busy, done);
    end
  endtask

  task automatic test_retarget();
    logic [6:0] exp_duty;
    do_reset();
    start = 1'b1; target = 7'd5; step_ticks = 8'd2;
    cyc(1);
    start = 1'b0;
    cyc(24);
    n_tests++;
    if (duty !== 7'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL retarget_pre: duty=%0d busy=%b, expected 3 1", duty, busy);
    end
    start = 1'b1; target = 7'd1; step_ticks = 8'd3;
    cyc(1);
    start = 1'b0;
    n_tests++;
    if (duty !== 7'd3 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL retarget_start: duty=%0d busy=%b done=%b, expected 3 1 0", duty, busy, done);
    end
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      exp_duty = 7'(3 - k / 12);
      n_tests++;
      if (duty !== exp_duty || busy !== (k < 24) || done !== (k == 24)) begin
        n_fail++;
        $display("FAIL retarget_down[+%0d]: duty=%0d busy=%b done=%b, expected %0d %b %b",
                 k, duty, busy, done, exp_duty, (k < 24), (k == 24));
      end
    end
    cyc(1);
    n_tests++;
    if (duty !== 7'd1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL retarget_after: duty=%0d busy=%b done=%b, expected 1 0 0", duty, busy, done);
    end
  endtask

  task automatic test_abort_same_target();
    do_reset();
    start = 1'b1; target = 7'd5; step_ticks = 8'd2;
    cyc(1);
    start = 1'b0;
    cyc(16);
    // abort and start together: abort must win
    abort = 1'b1; start = 1'b1; target = 7'd4;
    cyc(1);
    abort = 1'b0; start = 1'b0;
    n_tests++;
    if (duty !== 7'd2 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: duty=%0d busy=%b done=%b, expected 2 0 0", duty, busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_tests++;
      if (duty !== 7'd2 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle[%0d]: duty=%0d busy=%b done=%b, expected 2 0 0", i, duty, busy, done);
      end
    end
    start = 1'b1; target = 7'd2; step_ticks = 8'd5;
    cyc(1);
    start = 1'b0;
    n_tests++;
    if (duty !== 7'd2 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL same_target_done: duty=%0d busy=%b done=%b, expected 2 0 1", duty, busy, done);
    end
    cyc(1);
    n_tests++;
    if (duty !== 7'd2 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL same_target_after: duty=%0d busy=%b done=%b, expected 2 0 0", duty, busy, done);
    end
  endtask

  task automatic test_clamp_zero_step();
    logic       seen;
    logic [6:0] exp_duty;
    do_reset();
    start = 1'b1; target = 7'd98; step_ticks = 8'd1;
    cyc(1);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (seen !== 1'b1 || duty !== 7'd98) begin
      n_fail++;
      $display("FAIL reach_98: done_seen=%b duty=%0d, expected 1 98", seen, duty);
    end
    // issued while in DONE
    start = 1'b1; target = 7'd120; step_ticks = 8'd0;
    cyc(1);
    start = 1'b0;
    n_tests++;
    if (duty !== 7'd98 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_start: duty=%0d busy=%b done=%b, expected 98 1 0", duty, busy, done);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      exp_duty = 7'(98 + k / 4);
      n_tests++;
      if (duty !== exp_duty || busy !== (k < 8) || done !== (k == 8)) begin
        n_fail++;
        $display("FAIL clamp_ramp[+%0d]: duty=%0d busy=%b done=%b, expected %0d %b %b",
                 k, duty, busy, done, exp_duty, (k < 8), (k == 8));
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      n_tests++;
      if (duty !== 7'd100 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL clamp_hold[%0d]: duty=%0d busy=%b done=%b, expected 100 0 0", i, duty, busy, done);
      end
    end
  endtask

  task automatic test_midramp_reset();
    do_reset();
    start = 1'b1; target = 7'd5; step_ticks = 8'd2;
    cyc(1);
    start = 1'b0;
    cyc(24);
    n_tests++;
    if (duty !== 7'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: duty=%0d busy=%b, expected 3 1", duty, busy);
    end
    rstn = 1'b0; start = 1'b1; target = 7'd50; step_ticks = 8'd1;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      n_tests++;
      if (duty !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_in[%0d]: duty=%0d busy=%b done=%b, expected 0 0 0", i, duty, busy, done);
      end
    end
    rstn = 1'b1; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      n_tests++;
      if (duty !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_after[%0d]: duty=%0d busy=%b done=%b, expected 0 0 0", i, duty, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_ramp();
    test_retarget();
    test_abort_same_target();
    test_clamp_zero_step();
    test_midramp_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
